flag_pv_sequencer: RTL

- Sequences the P/V flag register bit: turns a decoded flag-update request into registered control strobes for it.
- Strobes generated: active-low one-hot source selects, PF_Write_PV, shadow-exchange (PR_Ex) and direct-load (PR_Write).
- Owns the iteration loop for repeating block ops (LDIR/CPIR class), which rewrite P/V each iteration until BC reaches zero.
- Sits between the instruction decoder and the F-register P/V slice.

---
 rtl/flag_pv_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/flag_pv_sequencer.sv
`default_nettype none
// ============================================================================
// flag_pv_sequencer: turns decoded P/V flag-update requests into registered
// strobes for the F-register P/V slice and runs the repeat-block-op loop.
// Revision: 1.0
// ============================================================================
module flag_pv_sequencer #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              Clk,
  input  logic              notReset,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic              af_load,
  output logic              op_ready,
  input  logic              iter_strobe,
  input  logic              is16bitEqual,
  input  logic              abort,
  output logic              notPF_Select_PV_bit18,
  output logic              notPF_Select_PV_bit20,
  output logic              notPF_Select_PV_bit25,
  output logic              notPF_Select_PV_bit27,
  output logic              notPF_Select_PV_bit33,
  output logic              PF_Write_PV,
  output logic              PR_Ex,
  output logic              notPR_Ex,
  output logic              PR_Write,
  output logic              notPR_Write,
  output logic              op_done,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_RPT_WAIT  = 3'd2,
    S_RPT_ISSUE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [ITER_W-1:0] C_MAX_ITER = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] C_SAT      = '1;
  // Active-low select vectors, bit order {33, 27, 25, 20, 18}.
  localparam logic [4:0] C_SEL_NONE = 5'b11111;
  localparam logic [4:0] C_SEL_18   = 5'b11110;
  localparam logic [4:0] C_SEL_20   = 5'b11101;
  localparam logic [4:0] C_SEL_25   = 5'b11011;
  localparam logic [4:0] C_SEL_27   = 5'b10111;
  localparam logic [4:0] C_SEL_33   = 5'b01111;

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_nsel, w_nsel_nxt;
  logic              r_pf_write, r_ex, r_nex, r_wr, r_nwr, r_done, r_ready;
  logic              w_ex_nxt, w_wr_nxt, w_done_nxt;
  logic [ITER_W-1:0] r_iter_count, w_cnt_nxt;
  logic              r_eq, w_eq_nxt;
  logic              r_abort, w_abort_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_nsel_nxt  = C_SEL_NONE;
    w_ex_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_iter_count;
    w_eq_nxt    = r_eq;
    w_abort_nxt = r_abort;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          w_abort_nxt = 1'b0;
          w_state_nxt = S_ISSUE;
          if (af_load) begin
            w_wr_nxt = 1'b1;
          end else begin
            case (op_code)
              3'd1: w_nsel_nxt = C_SEL_18;
              3'd2: w_nsel_nxt = C_SEL_20;
              3'd3: begin
                w_state_nxt = S_RPT_WAIT;
                w_cnt_nxt   = '0;
                w_eq_nxt    = 1'b0;
              end
              3'd4: w_nsel_nxt = C_SEL_25;
              3'd5: w_nsel_nxt = C_SEL_27;
              3'd6: w_nsel_nxt = C_SEL_33;
              3'd7: w_ex_nxt   = 1'b1;
              default: ;  // NOP: pass through ISSUE with no strobes
            endcase
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_DONE;
        w_done_nxt  = 1'b1;
      end
      S_RPT_WAIT: begin
        // An iteration that coincides with abort is still written first.
        if (iter_strobe) begin
          w_state_nxt = S_RPT_ISSUE;
          w_nsel_nxt  = C_SEL_20;
          w_cnt_nxt   = (r_iter_count == C_SAT) ? r_iter_count : r_iter_count + 1'b1;
          w_eq_nxt    = is16bitEqual;
          w_abort_nxt = abort;
        end else if (abort) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      S_RPT_ISSUE: begin
        if (r_eq || (r_iter_count == C_MAX_ITER) || r_abort || abort) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_RPT_WAIT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge notReset) begin
    if (!notReset) begin
      r_state      <= S_IDLE;
      r_nsel       <= C_SEL_NONE;
      r_pf_write   <= 1'b0;
      r_ex         <= 1'b0;
      r_nex        <= 1'b1;
      r_wr         <= 1'b0;
      r_nwr        <= 1'b1;
      r_done       <= 1'b0;
      r_ready      <= 1'b1;
      r_iter_count <= '0;
      r_eq         <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_nsel       <= w_nsel_nxt;
      r_pf_write   <= ~&w_nsel_nxt;
      r_ex         <= w_ex_nxt;
      r_nex        <= ~w_ex_nxt;
      r_wr         <= w_wr_nxt;
      r_nwr        <= ~w_wr_nxt;
      r_done       <= w_done_nxt;
      r_ready      <= (w_state_nxt == S_IDLE);
      r_iter_count <= w_cnt_nxt;
      r_eq         <= w_eq_nxt;
      r_abort      <= w_abort_nxt;
    end
  end

  assign notPF_Select_PV_bit18 = r_nsel[0];
  assign notPF_Select_PV_bit20 = r_nsel[1];
  assign notPF_Select_PV_bit25 = r_nsel[2];
  assign notPF_Select_PV_bit27 = r_nsel[3];
  assign notPF_Select_PV_bit33 = r_nsel[4];
  assign PF_Write_PV           = r_pf_write;
  assign PR_Ex                 = r_ex;
  assign notPR_Ex              = r_nex;
  assign PR_Write              = r_wr;
  assign notPR_Write           = r_nwr;
  assign op_done               = r_done;
  assign op_ready              = r_ready;
  assign iter_count            = r_iter_count;

endmodule
`default_nettype wire
